// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle RV32 subset (R, I-ALU, lw, sw, beq) over one shared memory port.
// Latency with memory always ready is 3-5 cycles per instruction; memory states stall until mem_ready_i.
module multicycle_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [6:0]       Op_i,
   input  logic             Zero_i,
   input  logic             mem_ready_i,
   output logic             PCWrite_o,
   output logic             PCSrc_o,
   output logic             TargetWrite_o,
   output logic             IorD_o,
   output logic             MemRead_o,
   output logic             MemWrite_o,
   output logic             IRWrite_o,
   output logic             MemtoReg_o,
   output logic             RegWrite_o,
   output logic [1:0]       ALUSrcA_o,
   output logic [1:0]       ALUSrcB_o,
   output logic [1:0]       ALUOp_o,
   output logic             halt_o,
   output logic [3:0]       state_o,
   output logic [CNT_W-1:0] retire_cnt_o
);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_EXEC_R = 4'd7,
      S_EXEC_I = 4'd8,
      S_ALUWB  = 4'd9,
      S_BRANCH = 4'd10,
      S_HALT   = 4'd11
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             retire;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      retire        = 1'b0;
      PCWrite_o     = 1'b0;
      PCSrc_o       = 1'b0;
      TargetWrite_o = 1'b0;
      IorD_o        = 1'b0;
      MemRead_o     = 1'b0;
      MemWrite_o    = 1'b0;
      IRWrite_o     = 1'b0;
      MemtoReg_o    = 1'b0;
      RegWrite_o    = 1'b0;
      ALUSrcA_o     = 2'd0;
      ALUSrcB_o     = 2'd0;
      ALUOp_o       = 2'b00;
      halt_o        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) state_d = S_FETCH;
         end
         S_FETCH: begin
            MemRead_o = 1'b1;
            // PC+4 is computed and committed only in the cycle the fetch completes
            if (mem_ready_i) begin
               IRWrite_o = 1'b1;
               PCWrite_o = 1'b1;
               ALUSrcB_o = 2'd1;
               state_d   = S_DECODE;
            end
         end
         S_DECODE: begin
            ALUSrcA_o     = 2'd2;
            ALUSrcB_o     = 2'd2;
            TargetWrite_o = 1'b1;
            case (Op_i)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXEC_R;
               OP_ITYPE:          state_d = S_EXEC_I;
               OP_BRANCH:         state_d = S_BRANCH;
               default:           state_d = S_HALT;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA_o = 2'd1;
            ALUSrcB_o = 2'd2;
            state_d   = Op_i[5] ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            IorD_o    = 1'b1;
            MemRead_o = 1'b1;
            if (mem_ready_i) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            RegWrite_o = 1'b1;
            MemtoReg_o = 1'b1;
            retire     = 1'b1;
         end
         S_MEMWR: begin
            IorD_o     = 1'b1;
            MemWrite_o = 1'b1;
            retire     = mem_ready_i;
         end
         S_EXEC_R: begin
            ALUSrcA_o = 2'd1;
            ALUOp_o   = 2'b10;
            state_d   = S_ALUWB;
         end
         S_EXEC_I: begin
            ALUSrcA_o = 2'd1;
            ALUSrcB_o = 2'd2;
            ALUOp_o   = 2'b10;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            RegWrite_o = 1'b1;
            retire     = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA_o = 2'd1;
            ALUOp_o   = 2'b01;
            PCSrc_o   = 1'b1;
            PCWrite_o = Zero_i;
            retire    = 1'b1;
         end
         S_HALT: begin
            halt_o = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      // start_i is sampled only at retirement so an instruction in flight always completes
      if (retire) state_d = start_i ? S_FETCH : S_IDLE;
   end

   assign cnt_d        = retire ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;
   assign state_o      = state_q;
   assign retire_cnt_o = cnt_q;

endmodule
